// File: rtl/bus_terminal_fifo.sv
// Bus terminal: a TX FIFO drained by the bus and an ID-filtered RX FIFO read by the device,
// both first-word-fall-through with registered heads, plus saturating loss counters.

module bus_terminal_fifo_q #(
   parameter int W     = 16,
   parameter int DEPTH = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         wr_req,
   input  logic [W-1:0] wr_data,
   input  logic         rd_req,
   output logic [W-1:0] head,
   output logic         vld,
   output logic         full
);
   localparam int            AW       = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0]   ONE_CNT  = (AW+1)'(1);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt;
   logic [AW:0]   cnt;
   logic          do_wr, do_rd;

   assign vld    = (cnt != '0);
   assign full   = (cnt == FULL_CNT);
   assign do_rd  = rd_req & vld;
   // A full FIFO still accepts a write when the head leaves on the same edge.
   assign do_wr  = wr_req & (~full | do_rd);
   assign rd_nxt = rd_ptr + 1'b1;

   // NOTE: storage has no reset; validity is tracked entirely by cnt, so clearing it is enough.
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         head   <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_nxt;
         case ({do_wr, do_rd})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
         // Head register mirrors the entry that will be at rd_ptr after this edge.
         if (do_rd) begin
            if (cnt != ONE_CNT) head <= mem[rd_nxt];
            else if (do_wr)     head <= wr_data;
         end else if (!vld && do_wr) begin
            head <= wr_data;
         end
      end
   end
endmodule

module bus_terminal_fifo #(
   parameter int                PCKG_SZ   = 16,
   parameter int                DEPTH     = 8,
   parameter int                ID_W      = 8,
   parameter logic [ID_W-1:0]   ID        = '0,
   parameter logic [ID_W-1:0]   BROADCAST = '1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               tx_wr,
   input  logic [PCKG_SZ-1:0] tx_data,
   output logic               tx_full,
   output logic               pndng,
   output logic [PCKG_SZ-1:0] D_pop,
   input  logic               pop,
   input  logic               push,
   input  logic [PCKG_SZ-1:0] D_push,
   output logic               rx_vld,
   output logic [PCKG_SZ-1:0] rx_data,
   input  logic               rx_rd,
   output logic [7:0]         tx_ovf_cnt,
   output logic [7:0]         rx_drop_cnt
);
   logic [ID_W-1:0] dest;
   logic            match, rx_full, tx_lost, rx_drop;

   assign dest    = D_push[PCKG_SZ-1 -: ID_W];
   assign match   = (dest == ID) || (dest == BROADCAST);
   assign tx_lost = tx_wr & tx_full & ~pop;
   assign rx_drop = push & (~match | (rx_full & ~rx_rd));

   bus_terminal_fifo_q #(.W(PCKG_SZ), .DEPTH(DEPTH)) u_tx (
      .clk     (clk),
      .reset   (reset),
      .wr_req  (tx_wr),
      .wr_data (tx_data),
      .rd_req  (pop),
      .head    (D_pop),
      .vld     (pndng),
      .full    (tx_full)
   );

   bus_terminal_fifo_q #(.W(PCKG_SZ), .DEPTH(DEPTH)) u_rx (
      .clk     (clk),
      .reset   (reset),
      .wr_req  (push & match),
      .wr_data (D_push),
      .rd_req  (rx_rd),
      .head    (rx_data),
      .vld     (rx_vld),
      .full    (rx_full)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_ovf_cnt  <= '0;
         rx_drop_cnt <= '0;
      end else begin
         if (tx_lost && tx_ovf_cnt != 8'hFF)  tx_ovf_cnt  <= tx_ovf_cnt + 1'b1;
         if (rx_drop && rx_drop_cnt != 8'hFF) rx_drop_cnt <= rx_drop_cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_bus_terminal_fifo.sv
// Directed bench for bus_terminal_fifo (ID=2, DEPTH=8): reset, ordering, overflow,
// RX filtering, counter saturation, pointer wrap and reset mid-operation.

module tb_bus_terminal_fifo;
   logic        clk = 1'b0;
   logic        reset;
   logic        tx_wr, pop, push, rx_rd;
   logic [15:0] tx_data, D_push;
   logic        tx_full, pndng, rx_vld;
   logic [15:0] D_pop, rx_data;
   logic [7:0]  tx_ovf_cnt, rx_drop_cnt;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   bus_terminal_fifo #(
      .PCKG_SZ(16), .DEPTH(8), .ID_W(8), .ID(8'h02), .BROADCAST(8'hFF)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .tx_wr       (tx_wr),
      .tx_data     (tx_data),
      .tx_full     (tx_full),
      .pndng       (pndng),
      .D_pop       (D_pop),
      .pop         (pop),
      .push        (push),
      .D_push      (D_push),
      .rx_vld      (rx_vld),
      .rx_data     (rx_data),
      .rx_rd       (rx_rd),
      .tx_ovf_cnt  (tx_ovf_cnt),
      .rx_drop_cnt (rx_drop_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Advance one edge; outputs are sampled 1ns after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int nexp;
      reset = 1'b0; tx_wr = 1'b1; tx_data = 16'h1234; pop = 1'b0;
      push = 1'b1; D_push = 16'h02AA; rx_rd = 1'b0;

      // 1: reset holds everything clear even with strobes active
      repeat (3) step();
      check("rst_pndng",  pndng,       0);
      check("rst_full",   tx_full,     0);
      check("rst_rxvld",  rx_vld,      0);
      check("rst_dpop",   D_pop,       0);
      check("rst_rxdata", rx_data,     0);
      check("rst_ovf",    tx_ovf_cnt,  0);
      check("rst_drop",   rx_drop_cnt, 0);
      tx_wr = 1'b0; push = 1'b0;
      step();
      reset = 1'b1;
      step();
      check("idle_pndng", pndng,  0);
      check("idle_rxvld", rx_vld, 0);

      // 2: TX ordering and latency
      tx_wr = 1'b1; tx_data = 16'hA001;
      step();
      check("tx_lat_pndng", pndng, 1);
      check("tx_lat_dpop",  D_pop, 16'hA001);
      tx_data = 16'hA002; step();
      tx_data = 16'hA003; step();
      tx_wr = 1'b0; pop = 1'b1;
      check("tx_ord0", D_pop, 16'hA001);
      step();
      check("tx_ord1", D_pop, 16'hA002);
      step();
      check("tx_ord2", D_pop, 16'hA003);
      step();
      check("tx_empty", pndng, 0);
      pop = 1'b0;

      // 3: TX full, overflow, write+pop while full
      tx_wr = 1'b1;
      for (int i = 0; i < 9; i++) begin
         tx_data = 16'hB000 + 16'(i);
         step();
         if (i == 6) check("tx_notfull7", tx_full, 0);
         if (i == 7) begin
            check("tx_full8", tx_full,    1);
            check("tx_ovf0",  tx_ovf_cnt, 0);
         end
      end
      check("tx_ovf1", tx_ovf_cnt, 1);
      tx_data = 16'hB100; pop = 1'b1;
      step();
      tx_wr = 1'b0;
      check("tx_full_wrpop", tx_full,    1);
      check("tx_ovf_keep",   tx_ovf_cnt, 1);
      for (int i = 1; i < 8; i++) begin
         check("tx_drain", D_pop, 16'hB000 + 16'(i));
         step();
      end
      check("tx_drain_last", D_pop, 16'hB100);
      step();
      check("tx_drained", pndng, 0);
      pop = 1'b0;

      // 4: RX filter
      push = 1'b1;
      D_push = 16'h02AB; step();
      D_push = 16'hFFCD; step();
      D_push = 16'h0511; step();
      push = 1'b0;
      check("rx_vld",    rx_vld,      1);
      check("rx_first",  rx_data,     16'h02AB);
      check("rx_drop1",  rx_drop_cnt, 1);
      rx_rd = 1'b1;
      step();
      check("rx_second", rx_data, 16'hFFCD);
      step();
      check("rx_empty",  rx_vld,  0);
      rx_rd = 1'b0;

      // 5: RX overflow and drop-counter saturation
      push = 1'b1;
      for (int i = 0; i < 8; i++) begin
         D_push = 16'h0200 + 16'(i);
         step();
      end
      check("rx_drop_nofull", rx_drop_cnt, 1);
      D_push = 16'h02F0;
      repeat (300) step();
      push = 1'b0;
      check("rx_drop_sat", rx_drop_cnt, 255);
      rx_rd = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check("rx_keep", rx_data, 16'h0200 + 16'(i));
         step();
      end
      check("rx_empty2", rx_vld, 0);
      rx_rd = 1'b0;
      check("tx_ovf_still1", tx_ovf_cnt, 1);

      // 6a: stream 20 packets across several pointer wraps
      nexp = 0;
      tx_wr = 1'b1;
      for (int k = 0; k < 23; k++) begin
         tx_wr   = (k < 20);
         tx_data = 16'hC000 + 16'(k);
         pop     = (k >= 3);
         if (pop) begin
            check("wrap_ord", D_pop, 16'hC000 + 16'(nexp));
            nexp++;
         end
         step();
      end
      tx_wr = 1'b0; pop = 1'b0;
      check("wrap_empty", pndng, 0);

      // 6b: reset with packets queued
      tx_wr = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         tx_data = 16'hD000 + 16'(i);
         step();
      end
      tx_wr = 1'b0;
      check("mid_pndng", pndng, 1);
      reset = 1'b0;
      #1;
      check("mid_rst_pndng", pndng,      0);
      check("mid_rst_dpop",  D_pop,      0);
      check("mid_rst_ovf",   tx_ovf_cnt, 0);
      step();
      reset = 1'b1;
      repeat (2) step();
      check("post_rst_pndng", pndng, 0);
      tx_wr = 1'b1; tx_data = 16'hE001;
      step();
      tx_wr = 1'b0; pop = 1'b1;
      check("post_rst_head", D_pop, 16'hE001);
      step();
      pop = 1'b0;
      check("post_rst_empty", pndng, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
